// File: rtl/jk_bank_sequencer.sv
// Command-driven excitation sequencer for a bank of WIDTH JK flip-flops.
// Accepts CLEAR/LOAD/UP/DOWN/TOGGLE commands and drives per-bit J/K lines from state, operand and bank Q.
module jk_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             cmd_abort,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             done,
    output logic             aborted,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_UP     = 3'b011;
    localparam logic [2:0] OP_DOWN   = 3'b100;
    localparam logic [2:0] OP_TOGGLE = 3'b101;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] arg_q;
    logic [WIDTH-1:0] cnt_q;
    logic             done_q;
    logic             aborted_q;
    logic             wrap_q;
    logic             err_q;

    logic [WIDTH-1:0] up_mask;
    logic [WIDTH-1:0] dn_mask;
    logic             counting;
    logic             step_en;
    logic             last_step;

    // A bit toggles on a count step when every lower bit is at its carry/borrow value.
    assign up_mask[0] = 1'b1;
    assign dn_mask[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_mask
            assign up_mask[gi] = &q_i[gi-1:0];
            assign dn_mask[gi] = ~|q_i[gi-1:0];
        end
    endgenerate

    assign counting  = (state_q == S_RUN) && ((op_q == OP_UP) || (op_q == OP_DOWN));
    assign step_en   = counting && (cnt_q != '0) && !cmd_abort;
    assign last_step = (cnt_q == '0) || (cnt_q == WIDTH'(1));

    always_comb begin
        j_o = '0;
        k_o = '0;
        if (state_q == S_RUN) begin
            case (op_q)
                OP_CLEAR: begin
                    j_o = '0;
                    k_o = '1;
                end
                OP_LOAD: begin
                    j_o = arg_q;
                    k_o = ~arg_q;
                end
                OP_TOGGLE: begin
                    j_o = arg_q;
                    k_o = arg_q;
                end
                OP_UP: begin
                    if (step_en) begin
                        j_o = up_mask;
                        k_o = up_mask;
                    end
                end
                OP_DOWN: begin
                    if (step_en) begin
                        j_o = dn_mask;
                        k_o = dn_mask;
                    end
                end
                default: begin
                    j_o = '0;
                    k_o = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            arg_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            wrap_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        arg_q   <= cmd_arg;
                        cnt_q   <= cmd_arg;
                        state_q <= S_RUN;
                        if (cmd_op[2:1] == 2'b11) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (counting) begin
                        // Wrap is judged on the pre-step Q, i.e. the value the step leaves.
                        if (step_en) begin
                            wrap_q <= (op_q == OP_UP) ? (&q_i) : (~|q_i);
                        end
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - WIDTH'(1);
                        end
                        if (cmd_abort || last_step) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            aborted_q <= cmd_abort;
                        end
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign wrap      = wrap_q;
    assign err       = err_q;

endmodule
